eva_ahb_req_arb: RTL and testbench

AHB-Lite master front-end for the EVA bench. It shares one AHB master port (htrans/hwrite/haddr/hwdata) between NREQ single-word requesters using round-robin arbitration. It issues NONSEQ/SINGLE word transfers with address/data-phase pipelining and returns in-order responses, including AHB two-cycle ERROR handling. It sits between bench/DPI requesters and the DUT slave port.

---
 rtl/eva_ahb_pkg.sv | 26 ++
 rtl/eva_rr_arb.sv | 45 ++++
 rtl/eva_ahb_req_arb.sv | 146 ++++++++++++++
 tb/tb_eva_ahb_req_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eva_ahb_pkg.sv
// AHB-Lite encodings, the in-flight transfer record and the front-end
// FSM states shared by the EVA requester arbiter.
package eva_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Wide enough for the largest supported requester count (8)
  localparam int unsigned IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             write;
    logic [31:0]      addr;
    logic [31:0]      wdata;
  } ahb_xfer_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_ERR2 = 1'b1
  } ahb_state_t;

endpackage

// File: rtl/eva_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from a request vector,
// with the priority pointer advancing past the winner when the grant is taken.
module eva_rr_arb #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          hclk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;
  logic          w_found;

  // Scan from the pointer upwards, wrapping, and keep the first hit
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_idx   = w_cand;
      end
    end
    if (i_en && w_found) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_en && w_found) begin
      r_ptr <= (32'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/eva_ahb_req_arb.sv
// AHB-Lite master front-end: round-robin shares one master port between
// NREQ single-word requesters, pipelining address and data phases.
module eva_ahb_req_arb
  import eva_ahb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic               hclk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [1:0]         htrans,
  output logic               hwrite,
  output logic [31:0]        haddr,
  output logic [31:0]        hwdata,
  output logic [2:0]         hsize,
  output logic [2:0]         hburst,
  input  logic               hready,
  input  logic [1:0]         hresp,
  input  logic [31:0]        hrdata
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  ahb_state_t      r_state, w_state_nxt;
  ahb_xfer_t       r_a, r_d, w_a_nxt, w_d_nxt, w_sel;
  logic            r_a_vld, r_d_vld, w_a_vld_nxt, w_d_vld_nxt;
  logic [NREQ-1:0] r_req_ready, r_rsp_valid, w_rsp_valid_nxt;
  logic [NREQ-1:0] w_elig, w_gnt, w_d_onehot;
  logic [31:0]     r_rsp_rdata, w_rsp_rdata_nxt;
  logic            r_rsp_err, w_rsp_err_nxt;
  logic            w_grant_en;
  logic [IW-1:0]   w_gidx;

  // A requester whose req_ready is high this cycle is still holding its old payload
  assign w_elig     = req_valid & ~r_req_ready;
  assign w_grant_en = (r_state == ST_RUN) && hready;

  eva_rr_arb #(.N(NREQ)) u_arb (
    .hclk  (hclk),
    .rst_n (rst_n),
    .i_req (w_elig),
    .i_en  (w_grant_en),
    .o_gnt (w_gnt),
    .o_idx (w_gidx)
  );

  always_comb begin
    w_sel      = '0;
    w_sel.idx  = IDX_W'(w_gidx);
    w_d_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel.write = req_write[i];
        w_sel.addr  = req_addr[32*i +: 32];
        w_sel.wdata = req_wdata[32*i +: 32];
      end
      w_d_onehot[i] = (32'(r_d.idx) == i);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_a_nxt         = r_a;
    w_a_vld_nxt     = r_a_vld;
    w_d_nxt         = r_d;
    w_d_vld_nxt     = r_d_vld;
    w_rsp_valid_nxt = '0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      ST_RUN: begin
        if (hready) begin
          if (r_d_vld) begin
            w_rsp_valid_nxt = w_d_onehot;
            w_rsp_rdata_nxt = r_d.write ? '0 : hrdata;
            w_rsp_err_nxt   = (hresp != HRESP_OKAY);
          end
          if (r_a_vld) begin
            w_d_nxt = r_a;
          end
          w_d_vld_nxt = r_a_vld;
          w_a_vld_nxt = |w_gnt;
          if (|w_gnt) begin
            w_a_nxt = w_sel;
          end
        end else if (r_d_vld && (hresp != HRESP_OKAY)) begin
          w_state_nxt = ST_ERR2;
        end
      end
      ST_ERR2: begin
        // Second ERROR cycle: retire D, keep A to re-present it
        if (hready) begin
          w_rsp_valid_nxt = w_d_onehot;
          w_rsp_rdata_nxt = r_d.write ? '0 : hrdata;
          w_rsp_err_nxt   = 1'b1;
          w_d_vld_nxt     = 1'b0;
          w_state_nxt     = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_a         <= '0;
      r_d         <= '0;
      r_a_vld     <= 1'b0;
      r_d_vld     <= 1'b0;
      r_req_ready <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_a         <= w_a_nxt;
      r_d         <= w_d_nxt;
      r_a_vld     <= w_a_vld_nxt;
      r_d_vld     <= w_d_vld_nxt;
      r_req_ready <= w_gnt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign htrans    = (r_a_vld && (r_state == ST_RUN)) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwrite    = r_a.write;
  assign haddr     = r_a.addr;
  assign hwdata    = r_d.wdata;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_eva_ahb_req_arb.sv
// Bench for eva_ahb_req_arb: random requesters and an AHB slave with waits and
// ERRORs, checked cycle by cycle against a transaction-level queue model.
module tb_eva_ahb_req_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = N * 32;

  logic          hclk;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [AW-1:0] req_addr, req_wdata;
  logic [31:0]   rsp_rdata, haddr, hwdata, hrdata;
  logic          rsp_err, hwrite, hready;
  logic [1:0]    htrans, hresp;
  logic [2:0]    hsize, hburst;

  eva_ahb_req_arb #(.NREQ(N)) dut (
    .hclk      (hclk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .hsize     (hsize),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    int unsigned idx;
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    int unsigned idx;
    logic [31:0] rdata;
    bit          err;
    int unsigned due;
  } rsp_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  // Requester side: pending payload per requester
  bit          pend[N];
  bit          pw[N];
  logic [31:0] pa[N];
  logic [31:0] pd[N];

  // Transaction-level model of the master port
  xfer_t       iss_q[$];   // granted, address not yet accepted by the slave
  bit          dph_vld = 1'b0;
  xfer_t       dph;        // transfer the slave holds in its data phase
  bit          err2 = 1'b0;
  rsp_t        rsp_q[$];
  int unsigned ptr = 0;
  int unsigned exp_gnt = N;  // requester expected to see req_ready now (N = none)

  int unsigned p_req = 0, p_wait = 0, p_err = 0;
  bit          fix_rd_en = 1'b0;
  logic [31:0] fix_rd = '0;
  logic [2:0]  scr_q[$];   // scripted {hready, hresp} for data-phase cycles
  logic [1:0]  err_code = 2'b01;
  bit          rst_pend = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_req(input int unsigned i, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    pend[i] = 1'b1;
    pw[i]   = w;
    pa[i]   = a;
    pd[i]   = d;
  endtask

  task automatic reset_checks();
    chk_eq("rst_htrans",    32'(htrans),    32'h0);
    chk_eq("rst_haddr",     haddr,          32'h0);
    chk_eq("rst_hwrite",    32'(hwrite),    32'h0);
    chk_eq("rst_hwdata",    hwdata,         32'h0);
    chk_eq("rst_req_ready", 32'(req_ready), 32'h0);
    chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk_eq("rst_rsp_rdata", rsp_rdata,      32'h0);
    chk_eq("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk_eq("hsize",         32'(hsize),     32'h2);
    chk_eq("hburst",        32'(hburst),    32'h0);
  endtask

  // One clock: check what is visible now, drive the next edge, predict it
  task automatic step();
    logic [N-1:0]  v_val, v_wr;
    logic [AW-1:0] v_addr, v_wdata;
    logic [2:0]    scr;
    logic          hr;
    logic [1:0]    rs;
    logic [31:0]   rd;
    int unsigned   best, bestd, d;
    bit            was_dph, exp_ns;
    xfer_t         x;
    rsp_t          r;

    exp_ns = (iss_q.size() != 0) && !err2;
    chk_eq("req_ready", 32'(req_ready), (exp_gnt < N) ? (32'd1 << exp_gnt) : 32'h0);
    chk_eq("htrans", 32'(htrans), exp_ns ? 32'h2 : 32'h0);
    if (exp_ns) begin
      chk_eq("haddr",  haddr, iss_q[0].addr);
      chk_eq("hwrite", 32'(hwrite), 32'(iss_q[0].write));
    end
    if (dph_vld && dph.write) chk_eq("hwdata", hwdata, dph.wdata);
    if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      chk_eq("rsp_valid", 32'(rsp_valid), 32'd1 << r.idx);
      chk_eq("rsp_err",   32'(rsp_err),   32'(r.err));
      if (!r.err) chk_eq("rsp_rdata", rsp_rdata, r.rdata);
    end else begin
      chk_eq("rsp_valid_idle", 32'(rsp_valid), 32'h0);
    end

    v_val = '0; v_wr = '0; v_addr = '0; v_wdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (exp_gnt == i) pend[i] = 1'b0;
      if (!pend[i] && ($urandom_range(99) < p_req))
        set_req(i, 1'($urandom_range(1)), $urandom() & 32'hFFFF_FFFC, $urandom());
      v_val   |= N'(pend[i]) << i;
      v_wr    |= N'(pw[i]) << i;
      v_addr  |= AW'(pa[i]) << (32 * i);
      v_wdata |= AW'(pd[i]) << (32 * i);
    end
    req_valid = v_val;
    req_write = v_wr;
    req_addr  = v_addr;
    req_wdata = v_wdata;

    rd = fix_rd_en ? fix_rd : $urandom();
    if (rst_pend) begin
      hr = 1'b0; rs = 2'b00;
    end else if (dph_vld && scr_q.size() != 0) begin
      scr = scr_q.pop_front();
      hr  = scr[2];
      rs  = scr[1:0];
    end else if (err2) begin
      hr = ($urandom_range(3) != 0);
      rs = err_code;
    end else if (dph_vld) begin
      d = $urandom_range(99);
      if (d < p_err) begin
        hr = 1'b0; rs = 2'($urandom_range(3, 1));
      end else if (d < p_err + p_wait) begin
        hr = 1'b0; rs = 2'b00;
      end else begin
        hr = 1'b1; rs = 2'b00;
      end
    end else begin
      hr = 1'b1; rs = 2'b00;
    end
    if (rs != 2'b00) err_code = rs;
    hready = hr;
    hresp  = rs;
    hrdata = rd;
    rst_n  = !rst_pend;

    if (rst_pend) begin
      iss_q.delete();
      rsp_q.delete();
      scr_q.delete();
      dph_vld  = 1'b0;
      err2     = 1'b0;
      ptr      = 0;
      exp_gnt  = N;
      rst_pend = 1'b0;
    end else begin
      best  = N;
      bestd = N;
      if (hr && !err2) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (pend[i] && exp_gnt != i) begin
            d = (i + N - ptr) % N;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
      end
      was_dph = dph_vld;
      if (hr && dph_vld) begin
        r.idx   = dph.idx;
        r.rdata = dph.write ? 32'h0 : rd;
        r.err   = err2 || (rs != 2'b00);
        r.due   = cyc + 1;
        rsp_q.push_back(r);
        dph_vld = 1'b0;
      end
      if (hr && !err2 && iss_q.size() != 0) begin
        dph     = iss_q.pop_front();
        dph_vld = 1'b1;
      end
      if (err2) err2 = !hr;
      else      err2 = was_dph && !hr && (rs != 2'b00);
      exp_gnt = best;
      if (best < N) begin
        x.idx   = best;
        x.write = pw[best];
        x.addr  = pa[best];
        x.wdata = pd[best];
        iss_q.push_back(x);
        ptr = (best + 1) % N;
      end
    end
    @(negedge hclk);
    cyc++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    hready = 1'b1; hresp = 2'b00; hrdata = '0;
    @(negedge hclk);
    @(negedge hclk);
    reset_checks();
    rst_n = 1'b1;

    // Single zero-wait read from requester 2
    fix_rd_en = 1'b1; fix_rd = 32'hDEADBEEF;
    set_req(2, 1'b0, 32'h100, 32'h0);
    run(6);
    fix_rd_en = 1'b0;

    // Write with two wait states
    scr_q.push_back(3'b000); scr_q.push_back(3'b000);
    set_req(1, 1'b1, 32'h20, 32'h55AA55AA);
    run(8);

    // ERROR on a write while a read sits in the address phase
    set_req(0, 1'b1, 32'h40, 32'h12345678);
    step();
    set_req(1, 1'b0, 32'h44, 32'h0);
    scr_q.push_back(3'b001); scr_q.push_back(3'b101);
    run(10);

    // hresp=2'b10 on a read is an ERROR too
    scr_q.push_back(3'b010); scr_q.push_back(3'b110);
    set_req(3, 1'b0, 32'h80, 32'h0);
    run(8);

    // All requesters continuously valid, zero-wait
    p_req = 100;
    run(40);
    p_req = 0;
    run(10);

    // Random traffic with wait states and errors
    p_req = 40; p_wait = 20; p_err = 8;
    run(3000);

    // Reset in the middle of a waited data phase
    p_err = 0;
    for (int unsigned k = 0; k < 100 && !dph_vld; k++) step();
    rst_pend = 1'b1;
    step();
    reset_checks();
    rst_n = 1'b1;

    p_err = 8;
    run(500);
    p_req = 0; p_wait = 0; p_err = 0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
